// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-and-add 64x64 multiply sequencer over the shared LEGv8 ALU
module alu_mul_sequencer #(
    parameter int N       = 64,
    parameter int SHAMT_W = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         ovf,
    output logic         alu_req,
    input  logic         alu_gnt,
    output logic [N-1:0] alu_A,
    output logic [N-1:0] alu_B,
    output logic [4:0]   alu_FS,
    output logic         alu_C0,
    input  logic [N-1:0] alu_F,
    input  logic [3:0]   alu_status
);

    localparam logic [4:0]   FS_ADD    = 5'b01000;
    localparam logic [4:0]   FS_LSL    = 5'b10000;
    localparam logic [4:0]   FS_LSR    = 5'b10100;
    localparam logic [N-1:0] SHIFT_ONE = {{(N-SHAMT_W){1'b0}}, SHAMT_W'(1)};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } state_t;

    state_t       state;
    logic [N-1:0] mcand;
    logic [N-1:0] mplier;
    logic [N-1:0] acc;
    logic         ovf_r;

    // Only the carry and zero flags matter to the multiply.
    logic unused_status;
    assign unused_status = alu_status[3] ^ alu_status[1];

    always_comb begin
        alu_req = 1'b0;
        alu_A   = '0;
        alu_B   = '0;
        alu_FS  = 5'b00000;
        alu_C0  = 1'b0;
        case (state)
            S_ADD: begin
                alu_req = 1'b1;
                alu_A   = acc;
                alu_B   = mcand;
                alu_FS  = FS_ADD;
            end
            S_SHL: begin
                alu_req = 1'b1;
                alu_A   = mcand;
                alu_B   = SHIFT_ONE;
                alu_FS  = FS_LSL;
            end
            S_SHR: begin
                alu_req = 1'b1;
                alu_A   = mplier;
                alu_B   = SHIFT_ONE;
                alu_FS  = FS_LSR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            ovf_r  <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= op_a;
                        mplier <= op_b;
                        acc    <= '0;
                        ovf_r  <= 1'b0;
                        busy   <= 1'b1;
                        if (op_b == '0) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            result <= '0;
                            ovf    <= 1'b0;
                        end else if (op_b[0]) begin
                            state <= S_ADD;
                        end else begin
                            state <= S_SHL;
                        end
                    end
                end
                S_ADD: begin
                    if (alu_gnt) begin
                        acc   <= alu_F;
                        ovf_r <= ovf_r | alu_status[2];
                        state <= S_SHL;
                    end
                end
                S_SHL: begin
                    // A set top bit shifted out only matters if more multiplier bits remain.
                    if (alu_gnt) begin
                        mcand <= alu_F;
                        ovf_r <= ovf_r | (mcand[N-1] & (mplier[N-1:1] != '0));
                        state <= S_SHR;
                    end
                end
                S_SHR: begin
                    if (alu_gnt) begin
                        mplier <= alu_F;
                        if (alu_status[0]) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            result <= acc;
                            ovf    <= ovf_r;
                        end else if (alu_F[0]) begin
                            state <= S_ADD;
                        end else begin
                            state <= S_SHL;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - randomized self-checking bench for alu_mul_sequencer
module tb_alu_mul_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [63:0] op_a = '0;
    logic [63:0] op_b = '0;
    logic        busy, done, ovf, alu_req, alu_C0;
    logic        alu_gnt = 1'b1;
    logic [63:0] result, alu_A, alu_B, alu_F;
    logic [4:0]  alu_FS;
    logic [3:0]  alu_status;
    logic        carry;

    int checks = 0;
    int errors = 0;

    alu_mul_sequencer #(.N(64), .SHAMT_W(6)) dut (
        .clock(clock), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result), .ovf(ovf),
        .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_A(alu_A), .alu_B(alu_B),
        .alu_FS(alu_FS), .alu_C0(alu_C0), .alu_F(alu_F), .alu_status(alu_status)
    );

    always #5 clock = ~clock;

    // Shared LEGv8 ALU: only the ADD / LSL / LSR functions are modelled.
    always_comb begin
        alu_F = '0;
        carry = 1'b0;
        case (alu_FS[4:2])
            3'b010:  {carry, alu_F} = {1'b0, alu_A} + {1'b0, alu_B} + {64'd0, alu_C0};
            3'b100:  alu_F = alu_A << alu_B[5:0];
            3'b101:  alu_F = alu_A >> alu_B[5:0];
            default: alu_F = '0;
        endcase
        alu_status = {1'b0, carry, alu_F[63], (alu_F == 64'd0)};
    end

    function automatic int ref_lat(input logic [63:0] b);
        int k = 0;
        int p = 0;
        for (int i = 0; i < 64; i++) begin
            if (b[i]) begin
                k = i + 1;
                p++;
            end
        end
        return 1 + 2 * k + p;
    endfunction

    function automatic logic [127:0] ref_prod(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] wa, wb;
        wa = {64'd0, a};
        wb = {64'd0, b};
        return wa * wb;
    endfunction

    int          r_lat, r_req, r_stalls;
    logic [63:0] r_res;
    logic        r_ovf, r_done, r_stable;

    // mode 0: grant always; 1: grant low for cycles s0..s0+slen-1; 2: random grant
    task automatic run_mul(input logic [63:0] a, input logic [63:0] b,
                           input int mode, input int s0, input int slen);
        int cyc;
        logic [63:0] ca, cb;
        logic [4:0]  cf;
        logic g;
        ca = '0; cb = '0; cf = '0;
        r_lat = 0; r_req = 0; r_stalls = 0; r_done = 1'b0; r_stable = 1'b1;
        r_res = '0; r_ovf = 1'b0;
        alu_gnt = 1'b1;
        @(negedge clock);
        op_a = a; op_b = b; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        cyc = 0;
        while (cyc < 600 && !r_done) begin
            @(negedge clock);
            cyc++;
            if (done) begin
                r_done = 1'b1; r_lat = cyc; r_res = result; r_ovf = ovf;
                alu_gnt = 1'b1;
            end else begin
                if (alu_req) r_req++;
                if (mode == 1) g = !(cyc >= s0 && cyc < s0 + slen);
                else if (mode == 2) g = ($urandom_range(0, 2) != 0);
                else g = 1'b1;
                alu_gnt = g;
                if (!g && busy) r_stalls++;
                if (mode == 1 && cyc == s0) begin
                    ca = alu_A; cb = alu_B; cf = alu_FS;
                end
                if (mode == 1 && cyc > s0 && cyc <= s0 + slen &&
                    (alu_A !== ca || alu_B !== cb || alu_FS !== cf || alu_req !== 1'b1))
                    r_stable = 1'b0;
            end
        end
        alu_gnt = 1'b1;
        checks++;
        if (!r_done) begin
            errors++;
            $display("FAIL timeout: no done for a=%h b=%h", a, b);
        end else begin
            @(negedge clock);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse: done=%b busy=%b after done, required 0 0", done, busy);
            end
        end
    endtask

    task automatic check_result(input string name, input logic [63:0] a, input logic [63:0] b, input int extra);
        logic [127:0] p;
        p = ref_prod(a, b);
        checks++;
        if (r_res !== p[63:0]) begin
            errors++;
            $display("FAIL %s result: a=%h b=%h got %h required %h", name, a, b, r_res, p[63:0]);
        end
        checks++;
        if (r_ovf !== (p[127:64] != 64'd0)) begin
            errors++;
            $display("FAIL %s ovf: got %b required %b", name, r_ovf, (p[127:64] != 64'd0));
        end
        checks++;
        if (r_lat !== ref_lat(b) + extra) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", name, r_lat, ref_lat(b) + extra);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({busy, done, ovf, alu_req, alu_C0} !== 5'b0 || result !== 64'd0 ||
            alu_A !== 64'd0 || alu_B !== 64'd0 || alu_FS !== 5'd0) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b ovf=%b req=%b c0=%b result=%h A=%h B=%h FS=%b, required all 0",
                     name, busy, done, ovf, alu_req, alu_C0, result, alu_A, alu_B, alu_FS);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        check_idle_outputs("reset_state");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_idle_outputs("post_reset_idle");
    endtask

    task automatic test_basic();
        run_mul(64'd6, 64'd7, 0, 0, 0);
        check_result("basic_6x7", 64'd6, 64'd7, 0);
        checks++;
        if (r_res !== 64'd42 || r_lat !== 10) begin
            errors++;
            $display("FAIL basic_const: result %0d lat %0d, required 42 10", r_res, r_lat);
        end
        checks++;
        if (r_req !== 9) begin
            errors++;
            $display("FAIL basic_req_cycles: got %0d required 9", r_req);
        end
    endtask

    task automatic test_zero();
        run_mul(64'd123, 64'd0, 0, 0, 0);
        check_result("zero", 64'd123, 64'd0, 0);
        checks++;
        if (r_req !== 0 || r_lat !== 1) begin
            errors++;
            $display("FAIL zero_req: req cycles %0d lat %0d, required 0 1", r_req, r_lat);
        end
    endtask

    task automatic test_overflow();
        run_mul(64'h8000_0000_0000_0000, 64'd2, 0, 0, 0);
        check_result("ovf_x2", 64'h8000_0000_0000_0000, 64'd2, 0);
        run_mul(64'h8000_0000_0000_0000, 64'd1, 0, 0, 0);
        check_result("ovf_x1", 64'h8000_0000_0000_0000, 64'd1, 0);
        checks++;
        if (r_ovf !== 1'b0 || r_lat !== 4) begin
            errors++;
            $display("FAIL x1_const: ovf %b lat %0d, required 0 4", r_ovf, r_lat);
        end
    endtask

    task automatic test_max();
        run_mul('1, '1, 0, 0, 0);
        check_result("max", '1, '1, 0);
        checks++;
        if (r_res !== 64'd1 || r_ovf !== 1'b1 || r_lat !== 193) begin
            errors++;
            $display("FAIL max_const: result %h ovf %b lat %0d, required 1 1 193", r_res, r_ovf, r_lat);
        end
    endtask

    task automatic test_stall();
        run_mul(64'd6, 64'd7, 1, 2, 5);
        check_result("stall", 64'd6, 64'd7, 5);
        checks++;
        if (r_stable !== 1'b1) begin
            errors++;
            $display("FAIL stall_stable: ALU operands changed during stall, stable=%b required 1", r_stable);
        end
    endtask

    task automatic test_reset_abort();
        bit stray;
        stray = 1'b0;
        @(negedge clock);
        op_a = 64'd6; op_b = 64'd7; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check_idle_outputs("abort_reset");
        repeat (3) begin
            @(negedge clock);
            if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
        end
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            if (done !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL abort_stray: done/busy seen after reset abort, required none");
        end
        run_mul(64'd3, 64'd5, 0, 0, 0);
        check_result("after_abort", 64'd3, 64'd5, 0);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int d1, d2;
        d1 = 0; d2 = 0; cyc = 0;
        alu_gnt = 1'b1;
        @(negedge clock);
        op_a = 64'd9; op_b = 64'd1; start = 1'b1;
        @(posedge clock);
        while (cyc < 30 && d2 == 0) begin
            @(negedge clock);
            cyc++;
            if (done) begin
                if (d1 == 0) d1 = cyc;
                else d2 = cyc;
            end
        end
        start = 1'b0;
        checks++;
        if (d1 !== 4 || d2 !== 9) begin
            errors++;
            $display("FAIL back_to_back: done at %0d and %0d, required 4 and 9", d1, d2);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_random(input int n, input int mode);
        logic [63:0] a, b;
        for (int i = 0; i < n; i++) begin
            a = {$urandom, $urandom} >> $urandom_range(0, 63);
            b = {$urandom, $urandom} >> $urandom_range(0, 63);
            if (i % 7 == 3) b = '0;
            run_mul(a, b, mode, 0, 0);
            check_result(mode == 0 ? "rand" : "rand_gnt", a, b, r_stalls);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_overflow();
        test_max();
        test_stall();
        test_reset_abort();
        test_back_to_back();
        test_random(25, 0);
        test_random(15, 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that computes an unsigned 64x64 -> 64-bit (low half) product using the shared combinational LEGv8 ALU, via shift-and-add.
- Drives the ALU operand, function-select and carry-in lines, registers the ALU F/status outputs each step, and arbitrates for the ALU with a req/gnt handshake.
- Sits beside the main datapath and serves the MUL instruction path.

Parameters:
- N, 64, operand/result width (ALU width; only 64 is supported).
- SHAMT_W, 6, width of the shift amount consumed by the ALU shifter (B[5:0]).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a multiply; sampled only in IDLE.
- op_a  in  N  multiplicand, captured when start is accepted.
- op_b  in  N  multiplier, captured when start is accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; result and ovf are valid.
- result  out  N  product low 64 bits; held until the next accepted start.
- ovf  out  1  unsigned overflow (true product >= 2^64); held with result.
- alu_req  out  1  request for the shared ALU.
- alu_gnt  in  1  ALU granted this cycle.
- alu_A  out  N  ALU A operand.
- alu_B  out  N  ALU B operand.
- alu_FS  out  5  ALU function select.
- alu_C0  out  1  ALU carry-in.
- alu_F  in  N  ALU result.
- alu_status  in  4  ALU flags {V,C,N,Z}.

Behaviour:
- Reset (async, active-low): state=IDLE; all internal registers, result, ovf, done, busy, alu_req, alu_A, alu_B, alu_FS and alu_C0 are 0.
- Reset asserted mid-operation aborts immediately; no done pulse is issued.
- Internal registers:
  - mcand (N): multiplicand, shifted left each step.
  - mplier (N): multiplier, shifted right each step.
  - acc (N): running product.
  - ovf_r: sticky overflow.
- ALU codes are fixed: ADD FS=5'b01000 with C0=0; LSL FS=5'b10000; LSR FS=5'b10100. FS[1:0]=00 (no inversion) always.
- ALU outputs are combinational from the state and registers.
- IDLE: alu_req=0, ALU drives 0.
  - On start=1: mcand<=op_a, mplier<=op_b, acc<=0, ovf_r<=0.
  - Next state is DONE if op_b==0, else ADD if op_b[0]=1, else SHL.
- ADD: alu_req=1, A=acc, B=mcand, ADD.
  - If gnt: acc<=alu_F; ovf_r<=ovf_r|alu_status[2] (C); next SHL.
- SHL: alu_req=1, A=mcand, B=1, LSL.
  - If gnt: mcand<=alu_F; ovf_r<=ovf_r|(mcand[63] & (mplier[63:1]!=0)); next SHR.
- SHR: alu_req=1, A=mplier, B=1, LSR.
  - If gnt: mplier<=alu_F.
  - If alu_status[0] (Z)=1, next DONE; else ADD if alu_F[0], else SHL.
- DONE: alu_req=0; done=1 for this single cycle; result<=acc, ovf<=ovf_r are registered on entry, so they are valid while done=1; next IDLE.
- Stall: in ADD/SHL/SHR with alu_gnt=0, all state and registers hold and alu_req stays 1. Operands stay stable during the stall.
- start is ignored while busy=1. start asserted in the DONE cycle is ignored; it is accepted in the following IDLE cycle.
- Latency with continuous grant: start-accept edge to done cycle = 1 + 2k + popcount(op_b).
  - k = index of the highest set bit of op_b, plus 1.
  - op_b=0 gives 1 cycle; the maximum is 193 cycles.
- Every stalled cycle adds exactly one cycle of latency.
- Result is op_a*op_b mod 2^64.
- busy = (state != IDLE), registered with the state.

Test Plan:
- op_a=6, op_b=7, gnt tied 1 -> done 10 cycles after start; result=42; ovf=0; alu_req high for 9 cycles.
- op_a=123, op_b=0 -> done on the next cycle; result=0; ovf=0; alu_req never asserted.
- op_a=64'h8000_0000_0000_0000, op_b=2 -> result=0, ovf=1. With op_b=1 instead -> result=64'h8000_0000_0000_0000, ovf=0, done after 4 cycles.
- op_a=op_b=64'hFFFF_FFFF_FFFF_FFFF -> result=1, ovf=1, done after exactly 193 cycles.
- op_a=6, op_b=7, alu_gnt low for 5 cycles starting in the first SHL -> done after 15 cycles; result=42; alu_A/alu_B/alu_FS stable throughout the stall.
- Assert reset in the 3rd busy cycle, release, then start op_a=3, op_b=5 -> all outputs 0 during reset; no stray done; then result=15 after 1+6+2=9 cycles.
